// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: byte-wise fetch of opcode, argument and operand
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_run                   fetch enable; low idles the block between instructions
//   i_dp                    data pointer, base of the operand-byte address
//   o_mem_addr, o_mem_req   byte read request to the shared memory port
//   i_mem_ack, i_mem_rdata  memory acknowledge and read data
//   o_inst, o_data          assembled instruction word and operand byte
//   o_inst_pc, o_next_pc    address of the opcode byte and of the following instruction
//   o_inst_valid            handshake valid toward the decoder
//   i_inst_ready            handshake ready from the decoder
//   i_pc_load, i_pc_value   PC redirect, applied only when an instruction is accepted
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic [15:0] i_dp,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    output logic [15:0] o_inst,
    output logic [7:0]  o_data,
    output logic [15:0] o_inst_pc,
    output logic [15:0] o_next_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    input  logic        i_pc_load,
    input  logic [15:0] i_pc_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_ARG,
        S_DAT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_inst;
    logic [7:0]  r_data;
    logic [15:0] r_inst_pc;
    logic [15:0] r_next_pc;
    logic [15:0] w_dat_addr;
    logic        w_data_sourced;

    // Operand address uses the live data pointer, so dp only matters while in DAT.
    assign w_dat_addr     = i_dp + {8'h00, r_inst[7:0]};
    // The opcode byte is already captured when the argument arrives.
    assign w_data_sourced = (r_inst[15:14] == 2'b10) && (r_inst[10:9] == 2'b01);

    // Request and address are pure decodes of state and registers, so an
    // outstanding request cannot move until the state advances on ack.
    always_comb begin
        o_mem_req  = 1'b0;
        o_mem_addr = 16'h0000;
        case (r_state)
            S_OP, S_ARG: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_pc;
            end
            S_DAT: begin
                o_mem_req  = 1'b1;
                o_mem_addr = w_dat_addr;
            end
            default: begin
                o_mem_req  = 1'b0;
                o_mem_addr = 16'h0000;
            end
        endcase
    end

    assign o_inst       = r_inst;
    assign o_data       = r_data;
    assign o_inst_pc    = r_inst_pc;
    assign o_next_pc    = r_next_pc;
    assign o_inst_valid = (r_state == S_HOLD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= 16'h0000;
            r_data    <= 8'h00;
            r_inst_pc <= 16'h0000;
            r_next_pc <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    if (i_mem_ack) begin
                        r_inst_pc     <= r_pc;
                        r_pc          <= r_pc + 16'd1;
                        r_inst[15:8]  <= i_mem_rdata;
                        // Opcode bit 7 clear means no argument byte follows.
                        if (!i_mem_rdata[7]) begin
                            r_inst[7:0] <= 8'h00;
                            r_data      <= 8'h00;
                            r_next_pc   <= r_pc + 16'd1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_state     <= S_ARG;
                        end
                    end
                end
                S_ARG: begin
                    if (i_mem_ack) begin
                        r_inst[7:0] <= i_mem_rdata;
                        r_pc        <= r_pc + 16'd1;
                        if (w_data_sourced) begin
                            r_state   <= S_DAT;
                        end else begin
                            r_data    <= 8'h00;
                            r_next_pc <= r_pc + 16'd1;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_DAT: begin
                    if (i_mem_ack) begin
                        r_data    <= i_mem_rdata;
                        // pc already points past the argument byte.
                        r_next_pc <= r_pc;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_inst_ready) begin
                        if (i_pc_load) begin
                            r_pc <= i_pc_value;
                        end
                        r_state <= i_run ? S_OP : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Front-end stage of the 16-bit CPU, directly upstream of the instruction decoder.
- Reads instruction bytes over a shared 8-bit memory port and assembles the 16-bit instruction word: opcode in the high byte, argument in the low byte.
- For data-sourced operands it also fetches the operand byte, so the decoder always receives a complete inst/data pair.
- Presents the result through a valid/ready handshake and accepts PC redirects from execute at the moment of hand-off.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  fetch enable; while low the block idles between instructions
- dp  in  16  data pointer, used for the operand-byte address
- mem_addr  out  16  memory byte address
- mem_req  out  1  memory request
- mem_ack  in  1  memory acknowledge; mem_rdata valid when high
- mem_rdata  in  8  memory read data
- inst  out  16  assembled instruction word
- data  out  8  fetched operand byte; 0 if none fetched
- inst_pc  out  16  address of the opcode byte of the current inst
- next_pc  out  16  address following the last byte of the current inst
- inst_valid  out  1  inst/data/inst_pc/next_pc are valid
- inst_ready  in  1  consumer accepts the current instruction
- pc_load  in  1  redirect request, honoured only on accept
- pc_value  in  16  redirect target

Behaviour:
- States:
  - IDLE: no request outstanding.
  - OP: fetching the opcode byte.
  - ARG: fetching the argument byte.
  - DAT: fetching the operand byte.
  - HOLD: instruction presented, inst_valid=1.
- Reset (asynchronous, any state):
  - state=IDLE, pc=RESET_PC.
  - inst=0, data=0, inst_pc=0, next_pc=0.
  - inst_valid=0, mem_req=0, mem_addr=0.
- mem_req and mem_addr are decoded from state and registers, so mem_req=1 exactly in OP/ARG/DAT.
- Memory handshake:
  - While mem_req=1, mem_addr is held stable until a rising edge samples mem_ack=1; rdata is captured on that edge.
  - Zero-wait memory (ack in the same cycle as req) is legal.
  - A request is never withdrawn or retargeted before its ack.
- IDLE: when run=1, go to OP with mem_addr=pc.
- OP, on ack:
  - inst_pc<=pc, pc<=pc+1, inst[15:8]<=rdata.
  - If rdata[7]=0 (zero-argument): inst[7:0]<=0, data<=0, next_pc<=pc+1, go to HOLD.
  - Otherwise go to ARG with mem_addr=pc+1.
- ARG, on ack:
  - inst[7:0]<=rdata, pc<=pc+1.
  - If inst[15:14]==2'b10 and inst[10:9]==2'b01 (data-sourced): go to DAT with mem_addr = dp + {8'h00, rdata}, mod 2^16.
  - Otherwise data<=0, next_pc<=pc+1, go to HOLD.
- DAT, on ack: data<=rdata, next_pc<=pc, go to HOLD. dp is sampled only while in DAT.
- HOLD:
  - inst_valid=1; inst, data, inst_pc and next_pc are held stable until accept.
  - Accept is inst_valid & inst_ready at a clock edge.
  - On accept: if pc_load=1, pc<=pc_value; else pc is unchanged (it already equals next_pc).
  - After accept, go to OP if run=1, else IDLE. inst_valid drops in the cycle after accept.
  - pc_load without accept is ignored.
- run=0 never aborts an in-flight fetch; it only stops the next fetch from starting.
- Latency with zero-wait memory: 1-byte inst valid 1 cycle after the OP request, 2-byte 2 cycles, data-sourced 3 cycles.
- Back-to-back throughput: one HOLD cycle plus one cycle per byte.
- All PC and address arithmetic is 16-bit and wraps: FFFF+1 = 0000.
- Reset asserted mid-transaction abandons the transaction immediately. The memory side must tolerate a dropped req.

Test Plan:
- Reset release with run=1, zero-wait memory, mem[0000]=0x01 → mem_req at 0000 → inst=0x0100, data=0, inst_pc=0000, next_pc=0001, inst_valid one cycle after the request.
- mem[0010..11]=0x88,0x05 (add immediate), pc=0010 → inst=0x8805, data=0, next_pc=0012; no DAT access occurs.
- mem[0020..21]=0x82,0x05, dp=0x0100, mem[0105]=0x7A → third access at 0105; inst=0x8205, data=0x7A, next_pc=0022.
- Memory with 3 wait states per byte → mem_addr stable and mem_req high across the wait cycles; same results as above, valid 4 cycles per byte later.
- Hold inst_ready=0 for 5 cycles, then assert with pc_load=1, pc_value=0x0400 → outputs stable throughout; next request at 0400. pc_load pulsed while ready=0 → no effect.
- Instruction 0x8A,0x01 at FFFF/0000 → argument read at 0000; next_pc=0001. Then rst_n pulsed low during an ARG wait → mem_req=0, inst_valid=0 immediately; restart at RESET_PC.
